regfile_port_arbiter: RTL
=========================

# regfile_port_arbiter

Shares the single-write, dual-read `registerFile` between two requesters (A: execute writeback, B: load/debug unit) under valid/ready handshakes. Arbitration is round-robin. After every reset the block runs a 32-cycle sweep that writes zero to all registers; requests are refused until the sweep completes. It sits between the requesters and `registerFile`, and it is the only driver of the register file's select, data and write-enable inputs.

## Interface
- `DATA_W`, 32, register data width
- `ADDR_W`, 5, register select width (32 registers)
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `reqA_valid` / `reqB_valid`  in  1  request present
- `reqA_ready` / `reqB_ready`  out  1  request accepted this cycle
- `reqA_rs1`, `reqA_rs2` / `reqB_rs1`, `reqB_rs2`  in  ADDR_W  read selects
- `reqA_rd` / `reqB_rd`  in  ADDR_W  write select
- `reqA_we` / `reqB_we`  in  1  write requested
- `reqA_wdata` / `reqB_wdata`  in  DATA_W  write data
- `respA_valid` / `respB_valid`  out  1  one-cycle pulse: read data valid
- `respA_rdata1`, `respA_rdata2` / `respB_rdata1`, `respB_rdata2`  out  DATA_W  read results
- `rf_readSel_1`, `rf_readSel_2`, `rf_writeSel`  out  ADDR_W  register file selects
- `rf_data`  out  DATA_W  register file write data
- `rf_we`  out  1  register file write enable
- `rf_readOut_1`, `rf_readOut_2`  in  DATA_W  register file combinational read data
- `init_done`  out  1  high once the zeroing sweep has completed

## Operation
- States: `ST_INIT`, `ST_RUN`. Reset sets state to `ST_INIT`, `cnt` to 0 and `last_grant` to B, so A has priority first.
- `ST_INIT` behaviour:
  - `rf_we`=1, `rf_writeSel`=`cnt`, `rf_data`=0.
  - Both readies are 0.
  - `cnt` increments each cycle. On the edge where `cnt`==31, the state moves to `ST_RUN` and `init_done` is set.
- `ST_RUN` arbitration:
  - Only one valid: that requester is granted.
  - Both valid: the requester not equal to `last_grant` is granted.
  - `ready` equals `grant` and is combinational from the valids.
  - `last_grant` updates only on an accepted transfer (valid && ready).
- Datapath while granted:
  - `rf_readSel_*`, `rf_writeSel` and `rf_data` come from the granted request.
  - `rf_we` = granted `we`.
  - With no grant, `rf_we`=0 and the selects/data are 0.
- On acceptance, `rf_readOut_1/2` are captured into the granted requester's `rdata` registers, and its `resp_valid` pulses high for exactly the next cycle.
- The `rdata` registers hold their value until that requester's next acceptance.
- A read response is produced for every accepted request, including write-only requests (`we`=1).
- Read and write of the same register in one transfer: the read returns the pre-write value, because the write lands at the edge.
- Back-to-back transfers: a register written by cycle N's transfer is read correctly by cycle N+1's transfer.
- Requesters hold valid and their fields stable until ready. The arbiter does not require this for correctness; a request dropped before acceptance is simply never serviced.
- Reset asserted mid-operation:
  - Every state bit returns to its reset value immediately.
  - A pending `resp_valid` is dropped.
  - The zeroing sweep restarts from register 0.

## Timing
- Reset values: `init_done`=0, both readies 0, both `resp_valid` 0, all `rdata` 0.
- While `reset` is low, `rf_we` is forced to 0 combinationally.
- Sweep timing:
  - The first rising edge after reset release writes register 0.
  - The 32nd edge writes register 31.
  - `init_done` is 1 from that edge onward.
  - The earliest possible grant is in the cycle that follows.
- Latency: `resp_valid` is high in cycle N+1 for a transfer accepted in cycle N.
- Throughput: one transfer per cycle. Alternation is guaranteed under continuous contention.
- No combinational path from the `resp_*` outputs to any input.

## Structure
- Package `regfile_pkg` holds `DATA_W`, `ADDR_W`, `NUM_REGS`=32 and the state enum (`ST_INIT`, `ST_RUN`).
- Sub-module `rr_arbiter2`: a 2-way round-robin arbiter. It takes both valids and the accept strobe, produces the grants, and holds the `last_grant` flop.
- The top level contains the FSM, the sweep counter, the selection muxing and the response registers.

## Test plan
- Reset release, no requests:
  - Exactly 32 writes of 0 to registers 0..31 in order.
  - `init_done` rises after the 32nd.
  - Readies stay 0 throughout.
- A writes reg 5 = 0xDEADBEEF with rs1=5:
  - `respA_rdata1`=0 (old value), `respA_valid` 1 cycle later.
  - The next A read of rs1=5 returns 0xDEADBEEF.
- A and B valid continuously for 6 cycles: grants are A,B,A,B,A,B, each `resp_valid` follows its grant by 1 cycle.
- B writes reg 7 = 0x1234 in cycle N; A reads rs2=7 in cycle N+1: `respA_rdata2`=0x1234.
- Requests valid during the sweep: no ready until `init_done`=1; the first grant goes to A.
- Reset pulsed low mid-stream with a response pending:
  - `resp_valid` drops to 0 at once and `init_done`=0.
  - The sweep restarts at register 0.
  - Registers previously written read back as 0 after the sweep.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths, FSM states and request payload for the register-file port arbiter.
package regfile_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } port_e;

    typedef struct packed {
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
        logic [ADDR_W-1:0] rd;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; last_grant only moves on an accepted transfer.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic valid_a,
    input  logic valid_b,
    input  logic accept,
    output logic grant_a_c,
    output logic grant_b_c
);

    port_e last_grant_q;

    // Grant the sole requester, or the one not granted last under contention.
    always_comb begin
        grant_a_c = 1'b0;
        grant_b_c = 1'b0;
        if (en) begin
            if (valid_a && (!valid_b || (last_grant_q == GRANT_B))) begin
                grant_a_c = 1'b1;
            end else if (valid_b) begin
                grant_b_c = 1'b1;
            end
        end
    end

    // Remember the winner of each accepted transfer; reset favours A first.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_q <= GRANT_B;
        end else if (accept) begin
            last_grant_q <= grant_b_c ? GRANT_B : GRANT_A;
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the single-write dual-read register file between requesters A and B,
// zeroing every register after reset before accepting any request.
module regfile_port_arbiter
    import regfile_pkg::*;
(
    input  logic              clock,
    input  logic              reset,

    input  logic              reqA_valid,
    output logic              reqA_ready,
    input  logic [ADDR_W-1:0] reqA_rs1,
    input  logic [ADDR_W-1:0] reqA_rs2,
    input  logic [ADDR_W-1:0] reqA_rd,
    input  logic              reqA_we,
    input  logic [DATA_W-1:0] reqA_wdata,

    input  logic              reqB_valid,
    output logic              reqB_ready,
    input  logic [ADDR_W-1:0] reqB_rs1,
    input  logic [ADDR_W-1:0] reqB_rs2,
    input  logic [ADDR_W-1:0] reqB_rd,
    input  logic              reqB_we,
    input  logic [DATA_W-1:0] reqB_wdata,

    output logic              respA_valid,
    output logic [DATA_W-1:0] respA_rdata1,
    output logic [DATA_W-1:0] respA_rdata2,
    output logic              respB_valid,
    output logic [DATA_W-1:0] respB_rdata1,
    output logic [DATA_W-1:0] respB_rdata2,

    output logic [ADDR_W-1:0] rf_readSel_1,
    output logic [ADDR_W-1:0] rf_readSel_2,
    output logic [ADDR_W-1:0] rf_writeSel,
    output logic [DATA_W-1:0] rf_data,
    output logic              rf_we,
    input  logic [DATA_W-1:0] rf_readOut_1,
    input  logic [DATA_W-1:0] rf_readOut_2,

    output logic              init_done
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              init_done_d;
    logic              rf_we_raw;
    logic              grant_a, grant_b;
    logic              accept_a, accept_b;
    req_t              req_a, req_b;

    assign req_a = '{rs1: reqA_rs1, rs2: reqA_rs2, rd: reqA_rd, we: reqA_we, wdata: reqA_wdata};
    assign req_b = '{rs1: reqB_rs1, rs2: reqB_rs2, rd: reqB_rd, we: reqB_we, wdata: reqB_wdata};

    rr_arbiter2 u_arb (
        .clock     (clock),
        .reset     (reset),
        .en        (state_q == ST_RUN),
        .valid_a   (reqA_valid),
        .valid_b   (reqB_valid),
        .accept    (accept_a || accept_b),
        .grant_a_c (grant_a),
        .grant_b_c (grant_b)
    );

    assign reqA_ready = grant_a;
    assign reqB_ready = grant_b;
    assign accept_a   = reqA_valid && grant_a;
    assign accept_b   = reqB_valid && grant_b;

    // Write enable is held off combinationally while reset is asserted.
    assign rf_we = reset && rf_we_raw;

    // State, sweep counter and init flag registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            init_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            init_done <= init_done_d;
        end
    end

    // Next state plus register-file port muxing: zero sweep, then granted request.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        init_done_d  = init_done;
        rf_we_raw    = 1'b0;
        rf_readSel_1 = '0;
        rf_readSel_2 = '0;
        rf_writeSel  = '0;
        rf_data      = '0;
        case (state_q)
            ST_INIT: begin
                rf_we_raw   = 1'b1;
                rf_writeSel = cnt_q;
                cnt_d       = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (grant_a) begin
                    rf_readSel_1 = req_a.rs1;
                    rf_readSel_2 = req_a.rs2;
                    rf_writeSel  = req_a.rd;
                    rf_data      = req_a.wdata;
                    rf_we_raw    = req_a.we;
                end else if (grant_b) begin
                    rf_readSel_1 = req_b.rs1;
                    rf_readSel_2 = req_b.rs2;
                    rf_writeSel  = req_b.rd;
                    rf_data      = req_b.wdata;
                    rf_we_raw    = req_b.we;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Capture read data for the accepted requester; valid pulses for one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            respA_valid  <= 1'b0;
            respB_valid  <= 1'b0;
            respA_rdata1 <= '0;
            respA_rdata2 <= '0;
            respB_rdata1 <= '0;
            respB_rdata2 <= '0;
        end else begin
            respA_valid <= accept_a;
            respB_valid <= accept_b;
            if (accept_a) begin
                respA_rdata1 <= rf_readOut_1;
                respA_rdata2 <= rf_readOut_2;
            end
            if (accept_b) begin
                respB_rdata1 <= rf_readOut_1;
                respB_rdata2 <= rf_readOut_2;
            end
        end
    end

endmodule
